byterec: RTL and testbench

BYTEREC -- requirements
Module: byterec

---
 rtl/kbd_pkg.sv | 44 ++++
 rtl/kbd_timeout.sv | 34 +++
 rtl/byterec.sv | 144 ++++++++++++++
 tb/tb_byterec.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 scan-code byte recogniser.
//   state_t        decoder FSM states
//   KC_*           prefix bytes, keyboard response codes and fake-shift codes
//   is_response()  byte is a keyboard response/status code that never forms a key
//   is_fake_shift  byte is a fake shift the keyboard wraps around extended keys
//   is_bad_byte()  byte is 00 or FF (buffer overrun / error), illegal mid-sequence
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EXT        = 3'd1,
    ST_BRK        = 3'd2,
    ST_EXT_BRK    = 3'd3,
    ST_PAUSE_SKIP = 3'd4
  } state_t;

  localparam logic [7:0] KC_E0 = 8'hE0;
  localparam logic [7:0] KC_F0 = 8'hF0;
  localparam logic [7:0] KC_E1 = 8'hE1;

  localparam logic [7:0] KC_ERR0  = 8'h00;
  localparam logic [7:0] KC_BAT   = 8'hAA;
  localparam logic [7:0] KC_ECHO  = 8'hEE;
  localparam logic [7:0] KC_ACK   = 8'hFA;
  localparam logic [7:0] KC_RESEND = 8'hFE;
  localparam logic [7:0] KC_ERR1  = 8'hFF;

  localparam logic [7:0] KC_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] KC_FAKE_RSHIFT = 8'h59;

  function automatic logic is_response(input logic [7:0] b);
    return (b == KC_ERR0) || (b == KC_BAT) || (b == KC_ECHO) ||
           (b == KC_ACK) || (b == KC_RESEND) || (b == KC_ERR1);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == KC_FAKE_LSHIFT) || (b == KC_FAKE_RSHIFT);
  endfunction

  function automatic logic is_bad_byte(input logic [7:0] b);
    return (b == KC_ERR0) || (b == KC_ERR1);
  endfunction

endpackage

// File: rtl/kbd_timeout.sv
// kbd_timeout: inter-byte watchdog for multi-byte scan-code sequences.
//   clk      system clock
//   resetN   asynchronous active-low reset
//   clear    zero the counter (new byte, or decoder idle)
//   enable   count while a sequence is in progress
//   expired  counter has reached TIMEOUT_CYCLES-1 while enabled
module kbd_timeout #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Saturates at LAST so a stalled sequence can never wrap and re-arm.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (enable && (r_count != LAST))
      r_count <= r_count + 1'b1;
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/byterec.sv
// byterec: turns a stream of PS/2 bytes into make / break / pause events.
//   clk      system clock, rising edge
//   resetN   asynchronous active-low reset
//   din      received byte, qualified by din_new
//   din_new  one-cycle strobe for a new byte
//   keyCode  {extended, scan code} of the last completed make or break
//   make     one-cycle pulse: key pressed
//   brakk    one-cycle pulse: key released
//   pause    one-cycle pulse: complete Pause-key sequence
//   seq_err  one-cycle pulse: sequence aborted (timeout or illegal byte)
module byterec
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int PAUSE_TAIL     = 7
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakk,
  output logic       pause,
  output logic       seq_err
);

  localparam int SW = (PAUSE_TAIL > 1) ? $clog2(PAUSE_TAIL + 1) : 1;
  localparam logic [SW-1:0] LAST_SKIP = SW'(PAUSE_TAIL - 1);

  state_t        r_state;
  logic [SW-1:0] r_skip;
  logic          w_expired;
  logic          w_clear;
  logic          w_enable;

  assign w_enable = (r_state != ST_IDLE);
  assign w_clear  = din_new || (r_state == ST_IDLE);

  kbd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetN (resetN),
    .clear  (w_clear),
    .enable (w_enable),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
      keyCode <= 9'h000;
      make    <= 1'b0;
      brakk   <= 1'b0;
      pause   <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      make    <= 1'b0;
      brakk   <= 1'b0;
      pause   <= 1'b0;
      seq_err <= 1'b0;
      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (din_new) begin
        case (r_state)
          ST_IDLE: begin
            if (din == KC_E0)
              r_state <= ST_EXT;
            else if (din == KC_F0)
              r_state <= ST_BRK;
            else if (din == KC_E1) begin
              r_state <= ST_PAUSE_SKIP;
              r_skip  <= '0;
            end else if (!is_response(din)) begin
              make    <= 1'b1;
              keyCode <= {1'b0, din};
            end
          end
          ST_EXT: begin
            if (is_bad_byte(din)) begin
              seq_err <= 1'b1;
              r_state <= ST_IDLE;
            end else if (din == KC_F0)
              r_state <= ST_EXT_BRK;
            else if (din == KC_E0)
              r_state <= ST_EXT;
            else if (is_fake_shift(din))
              r_state <= ST_IDLE;
            else begin
              make    <= 1'b1;
              keyCode <= {1'b1, din};
              r_state <= ST_IDLE;
            end
          end
          ST_BRK: begin
            if (is_bad_byte(din)) begin
              seq_err <= 1'b1;
              r_state <= ST_IDLE;
            end else if (din == KC_F0)
              r_state <= ST_BRK;
            else if (din == KC_E0) begin
              // A fresh extended prefix: abandon the break, start over as E0.
              seq_err <= 1'b1;
              r_state <= ST_EXT;
            end else begin
              brakk   <= 1'b1;
              keyCode <= {1'b0, din};
              r_state <= ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if (is_bad_byte(din)) begin
              seq_err <= 1'b1;
              r_state <= ST_IDLE;
            end else if (din == KC_E0) begin
              seq_err <= 1'b1;
              r_state <= ST_EXT;
            end else if (is_fake_shift(din))
              r_state <= ST_IDLE;
            else begin
              brakk   <= 1'b1;
              keyCode <= {1'b1, din};
              r_state <= ST_IDLE;
            end
          end
          ST_PAUSE_SKIP: begin
            // Pause tail bytes are counted, never decoded.
            if (r_skip == LAST_SKIP) begin
              pause   <= 1'b1;
              r_state <= ST_IDLE;
            end else
              r_skip <= r_skip + 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_expired) begin
        seq_err <= 1'b1;
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_byterec.sv
// tb_byterec: directed-vector bench for byterec (TIMEOUT_CYCLES=100).
module tb_byterec;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_new = 1'b0;
  logic [8:0] keyCode;
  logic       make, brakk, pause, seq_err;

  int checks = 0;
  int errors = 0;

  int cnt_make = 0, cnt_brakk = 0, cnt_pause = 0, cnt_err = 0, cnt_multi = 0;
  logic l_make, l_brakk, l_pause, l_err;

  byterec #(.TIMEOUT_CYCLES(100), .PAUSE_TAIL(7)) dut (
    .clk    (clk),
    .resetN (resetN),
    .din    (din),
    .din_new(din_new),
    .keyCode(keyCode),
    .make   (make),
    .brakk  (brakk),
    .pause  (pause),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (resetN) begin
      cnt_make  += int'(make);
      cnt_brakk += int'(brakk);
      cnt_pause += int'(pause);
      cnt_err   += int'(seq_err);
      if ((int'(make) + int'(brakk) + int'(pause) + int'(seq_err)) > 1)
        cnt_multi++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one clock, then sample the pulses the cycle after.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    din     = b;
    din_new = 1'b1;
    @(negedge clk);
    din_new = 1'b0;
    l_make  = make;
    l_brakk = brakk;
    l_pause = pause;
    l_err   = seq_err;
    $display("byte %02h -> make=%0d brakk=%0d pause=%0d seq_err=%0d keyCode=%03h",
             b, l_make, l_brakk, l_pause, l_err, keyCode);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  int b_make, b_brakk, b_pause, b_err;
  task automatic snap();
    b_make = cnt_make; b_brakk = cnt_brakk; b_pause = cnt_pause; b_err = cnt_err;
  endtask

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    #12;
    check_val("reset_keycode", 32'(keyCode), 32'h000);
    check_val("reset_pulses", {28'd0, make, brakk, pause, seq_err}, 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // Plain make, then single-cycle check, then break.
    send_byte(8'h1C);
    check_val("make_1C", 32'(l_make), 32'h1);
    check_val("make_1C_code", 32'(keyCode), 32'h01C);
    @(negedge clk);
    check_val("make_one_cycle", 32'(make), 32'h0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_val("brk_1C", 32'(l_brakk), 32'h1);
    check_val("brk_1C_code", 32'(keyCode), 32'h01C);

    // Extended make/break and fake shifts.
    send_byte(8'hE0);
    send_byte(8'h75);
    check_val("emake_75", {l_make, l_brakk}, 32'h2);
    check_val("emake_75_code", 32'(keyCode), 32'h175);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_val("ebrk_75", {l_make, l_brakk}, 32'h1);
    check_val("ebrk_75_code", 32'(keyCode), 32'h175);
    settle();
    snap();
    send_byte(8'hE0);
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h12);
    settle();
    check_val("fake_shift_pulses", 32'((cnt_make - b_make) + (cnt_brakk - b_brakk) + (cnt_err - b_err)), 32'h0);
    check_val("fake_shift_code", 32'(keyCode), 32'h175);

    // Pause sequence.
    snap();
    for (int i = 0; i < 8; i++) begin
      send_byte(pause_seq[i]);
      if (i == 6) check_val("pause_early", 32'(l_pause), 32'h0);
    end
    check_val("pause_8th", 32'(l_pause), 32'h1);
    settle();
    check_val("pause_count", 32'(cnt_pause - b_pause), 32'h1);
    check_val("pause_no_keys", 32'((cnt_make - b_make) + (cnt_brakk - b_brakk)), 32'h0);
    check_val("pause_code", 32'(keyCode), 32'h175);

    // Timeout after F0.
    snap();
    send_byte(8'hF0);
    repeat (90) @(negedge clk);
    #1;
    check_val("tmo_not_yet", 32'(cnt_err - b_err), 32'h0);
    repeat (30) @(negedge clk);
    #1;
    check_val("tmo_fired", 32'(cnt_err - b_err), 32'h1);
    repeat (120) @(negedge clk);
    #1;
    check_val("tmo_once", 32'(cnt_err - b_err), 32'h1);
    send_byte(8'h1C);
    check_val("tmo_then_make", {l_make, l_brakk}, 32'h2);

    // Byte in the expiry cycle wins over the timeout.
    settle();
    snap();
    send_byte(8'hF0);
    repeat (98) @(negedge clk);
    send_byte(8'h2B);
    check_val("race_brk", {l_brakk, l_err}, 32'h2);
    settle();
    check_val("race_no_err", 32'(cnt_err - b_err), 32'h0);
    check_val("race_code", 32'(keyCode), 32'h02B);

    // Illegal bytes mid-sequence.
    send_byte(8'hF0);
    send_byte(8'hE0);
    check_val("brk_e0_err", 32'(l_err), 32'h1);
    send_byte(8'h75);
    check_val("brk_e0_then_emake", {l_make, l_brakk}, 32'h2);
    check_val("brk_e0_code", 32'(keyCode), 32'h175);
    send_byte(8'hE0);
    send_byte(8'hFF);
    check_val("ext_ff_err", 32'(l_err), 32'h1);
    send_byte(8'h3A);
    check_val("after_ff_make", 32'(keyCode), 32'h03A);

    // Response codes, din without strobe.
    settle();
    snap();
    send_byte(8'hAA);
    send_byte(8'hFA);
    @(negedge clk);
    din = 8'h1C;
    repeat (3) @(negedge clk);
    settle();
    check_val("ignored_pulses", 32'((cnt_make - b_make) + (cnt_brakk - b_brakk) + (cnt_err - b_err)), 32'h0);
    check_val("ignored_code", 32'(keyCode), 32'h03A);

    // Back-to-back strobes.
    snap();
    @(negedge clk);
    din = 8'h1C; din_new = 1'b1;
    @(negedge clk);
    din = 8'h2A;
    @(negedge clk);
    din_new = 1'b0;
    settle();
    check_val("b2b_makes", 32'(cnt_make - b_make), 32'h2);
    check_val("b2b_code", 32'(keyCode), 32'h02A);

    // Asynchronous reset mid-sequence.
    send_byte(8'hE0);
    #2;
    resetN = 1'b0;
    #1;
    check_val("async_rst_code", 32'(keyCode), 32'h000);
    @(negedge clk);
    resetN = 1'b1;
    send_byte(8'h75);
    check_val("rst_make", {l_make, l_brakk}, 32'h2);
    check_val("rst_code", 32'(keyCode), 32'h075);

    settle();
    check_val("one_hot_pulses", 32'(cnt_multi), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
